regfile_init_loader: RTL and testbench

//  Synthesizable, parametrised successor to the bench-driven regfile preload used around top.
//  - Streams a configurable number of words into the InexRecur regfile, then into the state regfile,

---
 rtl/regfile_loader_pkg.sv | 7 +
 rtl/loader_wr_port.sv | 37 +++
 rtl/regfile_init_loader.sv | 91 +++++++++
 tb/tb_regfile_init_loader.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_loader_pkg.sv
// regfile_loader_pkg: shared FSM state type and default widths for the regfile init loader.
package regfile_loader_pkg;
    localparam int ADDR_W    = 12;
    localparam int IR_DATA_W = 32;
    localparam int ST_DATA_W = 18;
    typedef enum logic [2:0] {IDLE, LOAD_IR, LOAD_ST, SETTLE, RUN} state_t;
endpackage

// File: rtl/loader_wr_port.sv
// loader_wr_port: registered write-port driver with word index counter.
//   clk, rst   clock / async active-high reset
//   clr        sync clear of all outputs and the index counter
//   xfer       stream word accepted this cycle -> write it next cycle
//   last       this transfer is the final word; index returns to 0
//   wdata      word to write
//   idx        index the next accepted word will be written to
//   we/addr/data  registered write port; addr/data read 0 when we = 0
module loader_wr_port #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              xfer,
    input  logic              last,
    input  logic [DATA_W-1:0] wdata,
    output logic [ADDR_W-1:0] idx,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            we   <= 1'b0;
            addr <= '0;
            data <= '0;
            idx  <= '0;
        end else begin
            we   <= xfer;
            addr <= xfer ? idx : '0;
            data <= xfer ? wdata : '0;
            idx  <= xfer ? (last ? '0 : idx + 1'b1) : idx;
        end
    end
endmodule

// File: rtl/regfile_init_loader.sv
// regfile_init_loader: streams words into the InexRecur then state regfiles, then starts the accelerator.
//   cfg_start/cfg_ir_count/cfg_st_count  load request and word counts (sampled in IDLE)
//   abort                                sync abort to IDLE, drops in-flight transfer
//   s_valid/s_ready/s_data               input word stream
//   acc_done                             accelerator completion (sampled in RUN)
//   ran_*_InexRecur, ran_*_state_external  regfile write ports
//   is_start/busy/done                   run control and status
module regfile_init_loader #(
    parameter int ADDR_W      = regfile_loader_pkg::ADDR_W,
    parameter int IR_DATA_W   = regfile_loader_pkg::IR_DATA_W,
    parameter int ST_DATA_W   = regfile_loader_pkg::ST_DATA_W,
    parameter int START_DELAY = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_start,
    input  logic [ADDR_W:0]      cfg_ir_count,
    input  logic [ADDR_W:0]      cfg_st_count,
    input  logic                 abort,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [IR_DATA_W-1:0] s_data,
    input  logic                 acc_done,
    output logic                 ran_we_InexRecur,
    output logic [ADDR_W-1:0]    ran_w_addr_InexRecur,
    output logic [IR_DATA_W-1:0] ran_w_data_InexRecur,
    output logic                 ran_we_state_external,
    output logic [ADDR_W-1:0]    ran_w_addr_state_external,
    output logic [ST_DATA_W-1:0] ran_w_data_state_external,
    output logic                 is_start,
    output logic                 busy,
    output logic                 done
);
    import regfile_loader_pkg::*;
    localparam int SW = $clog2(START_DELAY + 1);
    localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W + 1)'(1) << ADDR_W;
    localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);
    state_t state, state_n;
    logic [ADDR_W:0] ir_cnt, st_cnt, ir_sat, st_sat;
    logic [ADDR_W-1:0] idx_ir, idx_st;
    logic [SW-1:0] scnt;
    logic xfer_ir, xfer_st, last_ir, last_st, settle_end;
    // any count with the top bit set is at least 2**ADDR_W, so clamp it there
    assign ir_sat = cfg_ir_count[ADDR_W] ? CNT_MAX : cfg_ir_count;
    assign st_sat = cfg_st_count[ADDR_W] ? CNT_MAX : cfg_st_count;
    assign xfer_ir = s_valid && !abort && state == LOAD_IR;
    assign xfer_st = s_valid && !abort && state == LOAD_ST;
    assign last_ir = xfer_ir && {1'b0, idx_ir} == ir_cnt - ONE;
    assign last_st = xfer_st && {1'b0, idx_st} == st_cnt - ONE;
    assign settle_end = scnt == SW'(START_DELAY - 1);
    always_comb begin
        state_n  = state;
        s_ready  = state == LOAD_IR || state == LOAD_ST;
        busy     = state != IDLE;
        is_start = state == RUN;
        case (state)
            IDLE:    if (cfg_start) state_n = ir_sat != 0 ? LOAD_IR : st_sat != 0 ? LOAD_ST : SETTLE;
            LOAD_IR: if (last_ir) state_n = st_cnt != 0 ? LOAD_ST : SETTLE;
            LOAD_ST: if (last_st) state_n = SETTLE;
            SETTLE:  if (settle_end) state_n = RUN;
            RUN:     if (acc_done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ir_cnt <= '0;
            st_cnt <= '0;
            scnt   <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            ir_cnt <= abort ? '0 : (state == IDLE && cfg_start) ? ir_sat : ir_cnt;
            st_cnt <= abort ? '0 : (state == IDLE && cfg_start) ? st_sat : st_cnt;
            scnt   <= (state == SETTLE && !abort && !settle_end) ? scnt + 1'b1 : '0;
            done   <= state == RUN && acc_done && !abort;
        end
    end
    loader_wr_port #(.ADDR_W(ADDR_W), .DATA_W(IR_DATA_W)) u_ir (
        .clk(clk), .rst(rst), .clr(abort), .xfer(xfer_ir), .last(last_ir),
        .wdata(s_data), .idx(idx_ir), .we(ran_we_InexRecur),
        .addr(ran_w_addr_InexRecur), .data(ran_w_data_InexRecur)
    );
    loader_wr_port #(.ADDR_W(ADDR_W), .DATA_W(ST_DATA_W)) u_st (
        .clk(clk), .rst(rst), .clr(abort), .xfer(xfer_st), .last(last_st),
        .wdata(s_data[ST_DATA_W-1:0]), .idx(idx_st), .we(ran_we_state_external),
        .addr(ran_w_addr_state_external), .data(ran_w_data_state_external)
    );
endmodule

// File: tb/tb_regfile_init_loader.sv
// tb_regfile_init_loader: directed scoreboard bench for regfile_init_loader.
module tb_regfile_init_loader;
    logic clk = 0, rst = 1, cfg_start = 0, abort = 0, s_valid = 0, acc_done = 0;
    logic [12:0] cfg_ir_count = 0, cfg_st_count = 0;
    logic [31:0] s_data = 0;
    logic s_ready, we_ir, we_st, is_start, busy, done;
    logic [11:0] addr_ir, addr_st;
    logic [31:0] data_ir;
    logic [17:0] data_st;
    int checks = 0, errors = 0, ir_writes = 0;
    typedef struct {logic st; logic [11:0] a; logic [31:0] d;} wr_t;
    wr_t q[$];

    regfile_init_loader dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_ir_count(cfg_ir_count),
        .cfg_st_count(cfg_st_count), .abort(abort), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .acc_done(acc_done),
        .ran_we_InexRecur(we_ir), .ran_w_addr_InexRecur(addr_ir), .ran_w_data_InexRecur(data_ir),
        .ran_we_state_external(we_st), .ran_w_addr_state_external(addr_st),
        .ran_w_data_state_external(data_st),
        .is_start(is_start), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // write monitor: every write must match the oldest scoreboard entry
    always @(negedge clk) begin
        wr_t e;
        if (!rst && (we_ir || we_st)) begin
            chk("one_port", {31'b0, we_ir & we_st}, 32'h0);
            checks++;
            assert (q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_write ir=%0b st=%0b", we_ir, we_st);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("wr_port", {31'b0, we_st}, {31'b0, e.st});
                chk("wr_addr", {20'b0, we_st ? addr_st : addr_ir}, {20'b0, e.a});
                chk("wr_data", we_st ? {14'b0, data_st} : data_ir, e.d);
                if (we_ir) ir_writes++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [12:0] ir, input logic [12:0] st);
        cfg_start = 1;
        cfg_ir_count = ir;
        cfg_st_count = st;
        tick;
        cfg_start = 0;
    endtask

    task automatic send(input logic st, input logic [11:0] a, input logic [31:0] d, input bit push);
        chk("s_ready", {31'b0, s_ready}, 32'h1);
        s_valid = 1;
        s_data = d;
        if (push) q.push_back('{st, a, st ? {14'b0, d[17:0]} : d});
        tick;
        s_valid = 0;
    endtask

    task automatic wait_start(input int exp);
        int n = 0;
        while (!is_start && n < 50) begin
            tick;
            n++;
        end
        chk("start_delay", n, exp);
    endtask

    task automatic run_end;
        acc_done = 1;
        tick;
        acc_done = 0;
        chk("run_end_is_start", {31'b0, is_start}, 32'h0);
        chk("run_end_done", {31'b0, done}, 32'h1);
        chk("run_end_busy", {31'b0, busy}, 32'h0);
        tick;
        chk("done_pulse_width", {31'b0, done}, 32'h0);
    endtask

    initial begin
        tick;
        tick;
        chk("rst_we_ir", {31'b0, we_ir}, 32'h0);
        chk("rst_we_st", {31'b0, we_st}, 32'h0);
        chk("rst_is_start", {31'b0, is_start}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_s_ready", {31'b0, s_ready}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        rst = 0;
        tick;
        // async reset in the middle of an IR write
        start(13'd2, 13'd0);
        send(1'b0, 12'd0, 32'h11, 1'b0);
        chk("mid_we_ir", {31'b0, we_ir}, 32'h1);
        rst = 1;
        #1;
        chk("mid_rst_we_ir", {31'b0, we_ir}, 32'h0);
        chk("mid_rst_is_start", {31'b0, is_start}, 32'h0);
        chk("mid_rst_busy", {31'b0, busy}, 32'h0);
        chk("mid_rst_s_ready", {31'b0, s_ready}, 32'h0);
        tick;
        rst = 0;
        tick;
        chk("post_rst_busy", {31'b0, busy}, 32'h0);
        chk("post_rst_s_ready", {31'b0, s_ready}, 32'h0);
        // one word each, then settle and run
        start(13'd1, 13'd1);
        send(1'b0, 12'd0, 32'h02010006, 1'b1);
        send(1'b1, 12'd0, 32'h0, 1'b1);
        chk("is_start_pre", {31'b0, is_start}, 32'h0);
        wait_start(3);
        run_end;
        chk("q_empty_1", q.size(), 32'h0);
        // four IR words with bubbles, then one state word
        start(13'd4, 13'd1);
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 12'(i), 32'hA000_0000 + 32'(i), 1'b1);
            if (i < 3) begin
                tick;
                chk("bubble_we_ir", {31'b0, we_ir}, 32'h0);
            end
        end
        chk("in_load_st", {31'b0, s_ready}, 32'h1);
        send(1'b1, 12'd0, 32'hFFFC_0005, 1'b1);
        wait_start(3);
        run_end;
        chk("q_empty_2", q.size(), 32'h0);
        // acc_done outside RUN is ignored, then an empty load
        acc_done = 1;
        tick;
        acc_done = 0;
        tick;
        chk("idle_done_ignored", {31'b0, done}, 32'h0);
        chk("idle_busy", {31'b0, busy}, 32'h0);
        start(13'd0, 13'd0);
        chk("empty_s_ready", {31'b0, s_ready}, 32'h0);
        chk("empty_busy", {31'b0, busy}, 32'h1);
        wait_start(3);
        run_end;
        // full regfile, with an oversized count that must clamp to 4096
        ir_writes = 0;
        start(13'h1FFF, 13'd0);
        for (int i = 0; i < 4096; i++) send(1'b0, 12'(i), $urandom, 1'b1);
        tick;
        chk("full_we_after", {31'b0, we_ir}, 32'h0);
        chk("full_addr_wrap", {20'b0, addr_ir}, 32'h0);
        chk("full_s_ready", {31'b0, s_ready}, 32'h0);
        chk("full_writes", ir_writes, 32'd4096);
        wait_start(2);
        run_end;
        chk("q_empty_3", q.size(), 32'h0);
        // abort while the third state word is offered
        start(13'd1, 13'd3);
        send(1'b0, 12'd0, 32'h1234_5678, 1'b1);
        send(1'b1, 12'd0, 32'h0001_1111, 1'b1);
        send(1'b1, 12'd1, 32'h0002_2222, 1'b1);
        chk("abort_s_ready", {31'b0, s_ready}, 32'h1);
        s_valid = 1;
        abort = 1;
        s_data = 32'h0003_3333;
        tick;
        s_valid = 0;
        abort = 0;
        chk("abort_we_st", {31'b0, we_st}, 32'h0);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_done", {31'b0, done}, 32'h0);
        for (int i = 0; i < 5; i++) tick;
        chk("abort_no_done", {31'b0, done}, 32'h0);
        chk("q_empty_4", q.size(), 32'h0);
        // cfg_start in RUN is ignored; abort in RUN gives no done
        start(13'd0, 13'd0);
        wait_start(3);
        start(13'd5, 13'd5);
        chk("run_cfg_is_start", {31'b0, is_start}, 32'h1);
        chk("run_cfg_s_ready", {31'b0, s_ready}, 32'h0);
        abort = 1;
        tick;
        abort = 0;
        chk("run_abort_is_start", {31'b0, is_start}, 32'h0);
        chk("run_abort_busy", {31'b0, busy}, 32'h0);
        chk("run_abort_done", {31'b0, done}, 32'h0);
        tick;
        chk("run_abort_done2", {31'b0, done}, 32'h0);
        chk("q_empty_end", q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
